// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg
// Shared ALU types and constants: slice width, sequencer states, index sizing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int SLICE_W  = 16;
    localparam int SLICE_LG = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Width needed to index n slices (never less than one bit).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/carry_look_ahead16bit.sv
// ============================================================================
// carry_look_ahead16bit
// 16-bit adder: four 4-bit groups with a second-level group carry look-ahead.
// Revision: 1.0
// ============================================================================
`default_nettype none

module carry_look_ahead16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    logic [15:0] p;
    logic [15:0] g;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [4:0]  gc;
    logic [15:0] bc;

    assign p = a ^ b;
    assign g = a & b;

    genvar j, k;
    generate
        for (j = 0; j < 4; j++) begin : g_grp
            assign gp[j] = &p[4*j +: 4];
            assign gg[j] = g[4*j+3]
                         | (p[4*j+3] & g[4*j+2])
                         | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                         | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            assign bc[4*j] = gc[j];
            for (k = 1; k < 4; k++) begin : g_bit
                assign bc[4*j+k] = g[4*j+k-1] | (p[4*j+k-1] & bc[4*j+k-1]);
            end
        end
    endgenerate

    // Group carries are computed in parallel from group propagate/generate.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    assign sum  = p ^ bc;
    assign cout = gc[4];

endmodule

`default_nettype wire

// File: rtl/alu_wide_add_seq.sv
// ============================================================================
// alu_wide_add_seq
// Multi-precision add/subtract, one 16-bit slice per clock, LS slice first.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_wide_add_seq
    import alu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [SLICE_W*WORDS-1:0] a,
    input  logic [SLICE_W*WORDS-1:0] b,
    output logic                   busy,
    output logic                   done,
    output logic [SLICE_W*WORDS-1:0] result,
    output logic                   cout,
    output logic                   overflow
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = clog2(WORDS);

    seq_state_t state;
    seq_state_t state_nxt;

    logic [W-1:0]         a_reg;
    logic [W-1:0]         b_reg;
    logic                 carry;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W+SLICE_LG-1:0] base;
    logic                 accept;
    logic                 last;
    logic [SLICE_W-1:0]   a_slice;
    logic [SLICE_W-1:0]   b_slice;
    logic [SLICE_W-1:0]   sum;
    logic                 slice_cout;

    assign base    = {idx, {SLICE_LG{1'b0}}};
    assign a_slice = a_reg[base +: SLICE_W];
    assign b_slice = b_reg[base +: SLICE_W];
    assign last    = (idx == IDX_W'(WORDS - 1));

    carry_look_ahead16bit u_cla (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry),
        .sum  (sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_nxt = state;
        accept    = start && (state != RUN);
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last)   state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so they stay glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN);
            done  <= (state_nxt == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1: the +1 enters as the initial carry.
            a_reg    <= a;
            b_reg    <= op_sub ? ~b : b;
            carry    <= op_sub;
            idx      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == RUN) begin
            result[base +: SLICE_W] <= sum;
            carry <= slice_cout;
            idx   <= idx + 1'b1;
            if (last) begin
                cout     <= slice_cout;
                overflow <= (a_reg[W-1] == b_reg[W-1]) && (sum[SLICE_W-1] != a_reg[W-1]);
            end
        end
    end

endmodule

`default_nettype wire
